game_frame_sequencer: RTL and testbench

- Frame-synchronous game-state sequencer between the game logic and the tile renderer.
- Latches the displayed board once per frame on the vsync rising edge and runs the WELCOME / PLAY / GAME_OVER mode machine.
- Tracks an independent highlight countdown per tile so newly added tiles can animate.
- Generalised to an N x N board, arbitrary tile code width and configurable highlight timing.

---
 rtl/game_frame_sequencer.sv | 111 +++++++++++
 tb/tb_game_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_frame_sequencer.sv
// game_frame_sequencer: latches the displayed board once per frame on vsync rise,
// runs the WELCOME/PLAY/GAME_OVER mode machine and per-tile highlight countdowns.
module game_frame_sequencer #(
    parameter int GRID_DIM         = 4,
    parameter int TILE_BITS        = 4,
    parameter int HIGHLIGHT_FRAMES = 25,
    parameter int CNT_W            = 5,
    parameter int PHASE_BITS       = 3,
    parameter int PHASE_SHIFT      = 1,
    parameter int OVER_HOLD_FRAMES = 60,
    localparam int NT = GRID_DIM * GRID_DIM,
    localparam int GW = NT * TILE_BITS,
    localparam int IW = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic [GW-1:0]            welcome_grid,
    input  logic [GW-1:0]            next_grid,
    input  logic                     added_tile_valid,
    input  logic [IW-1:0]            added_tile_index,
    input  logic                     game_over,
    input  logic                     btn_any,
    output logic [GW-1:0]            grid,
    output logic [NT-1:0]            new_tiles,
    output logic [NT*PHASE_BITS-1:0] tile_phase,
    output logic [1:0]               mode,
    output logic                     play_en,
    output logic                     restart
);
    typedef enum logic [1:0] {WELCOME = 2'd0, PLAY = 2'd1, OVER = 2'd2} mode_t;

    mode_t           mode_q, mode_d;
    logic [GW-1:0]   grid_q, grid_d;
    logic [7:0]      hold_q, hold_d;
    logic            vs_q, play_q, restart_q, restart_d;
    logic            tick, clr, load;

    assign tick = vsync & ~vs_q;
    assign load = added_tile_valid && mode_q == PLAY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= WELCOME;
            grid_q    <= '0;
            hold_q    <= '0;
            vs_q      <= 1'b0;
            play_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            grid_q    <= grid_d;
            hold_q    <= hold_d;
            vs_q      <= vsync;
            play_q    <= mode_d == PLAY;
            restart_q <= restart_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        grid_d    = grid_q;
        hold_d    = hold_q;
        restart_d = 1'b0;
        clr       = 1'b0;
        case (mode_q)
            WELCOME: if (tick) begin
                grid_d = welcome_grid;
                if (btn_any) begin
                    mode_d    = PLAY;
                    restart_d = 1'b1;
                end
            end
            PLAY: if (tick) begin
                grid_d = next_grid;
                if (game_over) begin
                    mode_d = OVER;
                    hold_d = '0;
                end
            end
            OVER: if (tick) begin
                // restart is only honoured once the hold time has fully elapsed
                if (hold_q == 8'(OVER_HOLD_FRAMES) && btn_any) begin
                    mode_d    = WELCOME;
                    restart_d = 1'b1;
                    clr       = 1'b1;
                end else if (hold_q != 8'(OVER_HOLD_FRAMES)) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: mode_d = WELCOME;
        endcase
    end

    for (genvar i = 0; i < NT; i++) begin : g_tile
        logic [CNT_W-1:0] cnt_q, cnt_d;
        // a load on a tick cycle wins over the decrement for that tile
        always_comb cnt_d = clr ? '0
                          : (load && added_tile_index == IW'(i)) ? CNT_W'(HIGHLIGHT_FRAMES)
                          : (tick && cnt_q != '0) ? cnt_q - CNT_W'(1)
                          : cnt_q;
        always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
        assign new_tiles[i] = |cnt_q;
        assign tile_phase[i*PHASE_BITS +: PHASE_BITS] = PHASE_BITS'(cnt_q >> PHASE_SHIFT);
    end

    assign grid    = grid_q;
    assign mode    = mode_q;
    assign play_en = play_q;
    assign restart = restart_q;
endmodule

// File: tb/tb_game_frame_sequencer.sv
// tb_game_frame_sequencer: directed scoreboard bench for game_frame_sequencer,
// default 4x4 instance plus a 5x5 / 5-bit-tile instance sharing control inputs.
module tb_game_frame_sequencer;
    typedef logic [127:0] v_t;
    typedef struct {
        string tag;
        v_t    v;
    } exp_t;

    logic         clk = 0, rst_n = 0, vsync = 0, btn_any = 0, game_over = 0, added_tile_valid = 0;
    logic [63:0]  welcome_grid = 0, next_grid = 0, grid;
    logic [3:0]   idx0 = 0;
    logic [15:0]  new_tiles;
    logic [47:0]  tile_phase;
    logic [1:0]   mode;
    logic         play_en, restart;
    logic [124:0] wg1 = 0, ng1 = 0, grid1;
    logic [4:0]   idx1 = 0;
    logic [24:0]  nt1;
    logic [74:0]  tp1;
    logic [1:0]   mode1;
    logic         pe1, rs1;

    exp_t sb[$];
    int   n_assert = 0, n_fail = 0, n_restart = 0, n_long = 0;
    logic rs_prev = 0;
    logic [63:0] w, n2;

    game_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .welcome_grid(welcome_grid), .next_grid(next_grid),
        .added_tile_valid(added_tile_valid), .added_tile_index(idx0), .game_over(game_over),
        .btn_any(btn_any), .grid(grid), .new_tiles(new_tiles), .tile_phase(tile_phase),
        .mode(mode), .play_en(play_en), .restart(restart)
    );

    game_frame_sequencer #(.GRID_DIM(5), .TILE_BITS(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .welcome_grid(wg1), .next_grid(ng1),
        .added_tile_valid(added_tile_valid), .added_tile_index(idx1), .game_over(game_over),
        .btn_any(btn_any), .grid(grid1), .new_tiles(nt1), .tile_phase(tp1),
        .mode(mode1), .play_en(pe1), .restart(rs1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_restart <= n_restart + int'(restart);
        n_long    <= n_long + int'(restart && rs_prev);
        rs_prev   <= restart;
    end

    task automatic push(input string tag, input v_t v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input v_t obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise();
        vsync = 1;
        step(1);
    endtask

    task automatic fall();
        step(7);
        vsync = 0;
        step(8);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            rise();
            fall();
        end
    endtask

    initial begin
        step(3);
        push("rst_grid", 0); push("rst_new", 0); push("rst_phase", 0);
        push("rst_mode", 0); push("rst_play", 0); push("rst_restart", 0);
        chk(v_t'(grid)); chk(v_t'(new_tiles)); chk(v_t'(tile_phase));
        chk(v_t'(mode)); chk(v_t'(play_en)); chk(v_t'(restart));
        rst_n = 1;
        step(2);

        for (int k = 0; k < 3; k++) begin
            welcome_grid = {$urandom, $urandom};
            wg1 = 125'({$urandom, $urandom, $urandom, $urandom});
            push("wel_grid", v_t'(welcome_grid)); push("wel_mode", 0); push("wel_grid1", v_t'(wg1));
            rise();
            chk(v_t'(grid)); chk(v_t'(mode)); chk(v_t'(grid1));
            fall();
        end
        added_tile_valid = 1; idx0 = 2;
        step(1);
        added_tile_valid = 0;
        push("wel_valid_ignored", 0); chk(v_t'(new_tiles));
        vsync = 1;
        step(1);
        btn_any = 1;
        step(3);
        btn_any = 0;
        push("btn_no_tick_mode", 0); chk(v_t'(mode));
        fall();
        push("wel_no_restart", 0); chk(v_t'(n_restart));

        w = {$urandom, $urandom};
        welcome_grid = w; next_grid = {$urandom, $urandom}; btn_any = 1;
        push("start_grid", v_t'(w)); push("start_mode", 1); push("start_play", 1); push("start_restart", 1);
        rise();
        chk(v_t'(grid)); chk(v_t'(mode)); chk(v_t'(play_en)); chk(v_t'(restart));
        btn_any = 0;
        push("start_restart_drop", 0);
        step(1);
        chk(v_t'(restart));
        fall();
        push("play_grid", v_t'(next_grid));
        rise();
        chk(v_t'(grid));
        fall();

        added_tile_valid = 1; idx0 = 5;
        step(1);
        added_tile_valid = 0;
        push("hl_new", 16'h0020); push("hl_phase", 4);
        chk(v_t'(new_tiles)); chk(v_t'(tile_phase[17:15]));
        frames(10);
        push("hl_phase_mid", 7); chk(v_t'(tile_phase[17:15]));
        frames(14);
        push("hl_new_last", 16'h0020); chk(v_t'(new_tiles));
        frames(1);
        push("hl_new_done", 0); chk(v_t'(new_tiles));
        frames(5);
        push("hl_no_underflow_new", 0); push("hl_no_underflow_phase", 0);
        chk(v_t'(new_tiles)); chk(v_t'(tile_phase));

        added_tile_valid = 1; idx0 = 7;
        step(1);
        added_tile_valid = 0;
        frames(15);
        push("col_pre_phase7", 5); chk(v_t'(tile_phase[23:21]));
        vsync = 1; added_tile_valid = 1; idx0 = 3;
        step(1);
        added_tile_valid = 0;
        push("col_new", 16'h0088); push("col_phase7", 4);
        chk(v_t'(new_tiles)); chk(v_t'(tile_phase[23:21]));
        fall();
        frames(9);
        push("col_new_after", 16'h0008); push("col_phase3", 0);
        chk(v_t'(new_tiles)); chk(v_t'(tile_phase[11:9]));
        added_tile_valid = 1; idx0 = 3;
        step(1);
        added_tile_valid = 0;
        push("reload_phase3", 4); chk(v_t'(tile_phase[11:9]));

        n2 = {$urandom, $urandom};
        next_grid = n2; game_over = 1;
        push("over_grid", v_t'(n2)); push("over_mode", 2); push("over_play", 0);
        rise();
        chk(v_t'(grid)); chk(v_t'(mode)); chk(v_t'(play_en));
        game_over = 0;
        fall();
        next_grid = {$urandom, $urandom};
        push("over_frozen", v_t'(n2));
        frames(1);
        chk(v_t'(grid));
        added_tile_valid = 1; idx0 = 2;
        step(1);
        added_tile_valid = 0;
        push("over_valid_ignored", 0); chk(v_t'(new_tiles & 16'h0004));
        frames(29);
        btn_any = 1;
        rise();
        btn_any = 0;
        push("over_btn_early", 2); chk(v_t'(mode));
        fall();
        frames(28);
        btn_any = 1;
        rise();
        btn_any = 0;
        push("over_btn_boundary", 2); chk(v_t'(mode));
        fall();
        btn_any = 1;
        push("exit_mode", 0); push("exit_restart", 1); push("exit_new", 0); push("exit_play", 0);
        rise();
        chk(v_t'(mode)); chk(v_t'(restart)); chk(v_t'(new_tiles)); chk(v_t'(play_en));
        btn_any = 0;
        fall();
        push("restart_count", 2); chk(v_t'(n_restart));

        btn_any = 1;
        rise();
        btn_any = 0;
        fall();
        added_tile_valid = 1; idx0 = 9; idx1 = 24;
        step(1);
        added_tile_valid = 0;
        push("d1_new", 25'h1000000); push("d1_phase24", 4);
        chk(v_t'(nt1)); chk(v_t'(tp1[74:72]));
        added_tile_valid = 1; idx1 = 25;
        step(1);
        added_tile_valid = 0;
        push("d1_idx25_ignored", 25'h1000000); chk(v_t'(nt1));
        frames(2);
        push("d1_phase_dec", 3); chk(v_t'(tp1[74:72]));
        game_over = 1;
        rise();
        game_over = 0;
        fall();
        push("pre_rst_mode", 2); push("pre_rst_new", 16'h0200);
        chk(v_t'(mode)); chk(v_t'(new_tiles));
        rst_n = 0;
        step(1);
        push("rst2_grid", 0); push("rst2_new", 0); push("rst2_phase", 0); push("rst2_mode", 0);
        push("rst2_play", 0); push("rst2_restart", 0); push("rst2_d1_new", 0); push("rst2_d1_grid", 0);
        push("rst2_d1_mode", 0);
        chk(v_t'(grid)); chk(v_t'(new_tiles)); chk(v_t'(tile_phase)); chk(v_t'(mode));
        chk(v_t'(play_en)); chk(v_t'(restart)); chk(v_t'(nt1)); chk(v_t'(grid1)); chk(v_t'(mode1));
        rst_n = 1;
        step(2);
        push("no_long_restart", 0); push("restart_total", 3);
        chk(v_t'(n_long)); chk(v_t'(n_restart));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
